// File: rtl/sa_tile_sequencer.sv
// Input FIFO, tile fire sequencer and per-lane skew line for a ROWS x COLS systolic array.
// A tile pops cfg_k beats into the skew line, then injects ROWS+COLS-1 zero fires to drain it.

module sa_skew_lane #(
  parameter int W      = 8,
  parameter int STAGES = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [STAGES-1:0][W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (clr) begin
      sr_d = '0;
    end else if (en) begin
      sr_d[0] = din;
      for (int i = 1; i < STAGES; i++) sr_d[i] = sr_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) sr_q <= '0;
    else       sr_q <= sr_d;
  end

  assign dout = sr_q[STAGES-1];
endmodule

module sa_tile_sequencer #(
  parameter int ROWS    = 8,
  parameter int COLS    = 8,
  parameter int INWIDTH = 8,
  parameter int DEPTH   = 16,
  parameter int KMAXW   = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ROWS*INWIDTH-1:0]    in_a,
  input  logic [COLS*INWIDTH-1:0]    in_w,
  input  logic                       tile_start,
  input  logic [KMAXW-1:0]           cfg_k,
  input  logic                       cfg_accum,
  input  logic                       flush,
  output logic                       arr_fire,
  output logic                       arr_clr,
  output logic [ROWS*INWIDTH-1:0]    arr_a,
  output logic [COLS*INWIDTH-1:0]    arr_w,
  output logic                       tile_done,
  input  logic                       done_ack,
  output logic                       busy,
  output logic                       err,
  output logic [$clog2(DEPTH):0]     fifo_cnt
);
  localparam int AW  = ROWS*INWIDTH;
  localparam int WW  = COLS*INWIDTH;
  localparam int EW  = AW + WW;
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int NFL = ROWS + COLS - 1;
  localparam int FLW = $clog2(NFL + 1);
  localparam logic [FLW-1:0] FL_LAST = FLW'(NFL - 1);

  typedef enum logic [1:0] {S_IDLE, S_FIRE, S_FLUSH, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [KMAXW-1:0]  k_cnt_q, k_cnt_d, cfg_k_q, cfg_k_d;
  logic [FLW-1:0]    fl_cnt_q, fl_cnt_d;
  logic              fire_q, fire_d, clr_q, clr_d, err_q, err_d;
  logic              push, pop;
  logic [EW-1:0]     head, skew_din;
  logic [EW-1:0]     mem_q [DEPTH];

  assign in_ready = (cnt_q != CW'(DEPTH));
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    state_d  = state_q;
    k_cnt_d  = k_cnt_q;
    cfg_k_d  = cfg_k_q;
    fl_cnt_d = fl_cnt_q;
    fire_d   = 1'b0;
    clr_d    = 1'b0;
    err_d    = 1'b0;
    pop      = 1'b0;
    skew_din = '0;
    push     = in_valid && in_ready && !flush;

    unique case (state_q)
      S_IDLE: begin
        if (tile_start) begin
          if (cfg_k == '0) begin
            err_d = 1'b1;
          end else begin
            cfg_k_d  = cfg_k;
            k_cnt_d  = '0;
            fl_cnt_d = '0;
            clr_d    = !cfg_accum;
            state_d  = S_FIRE;
          end
        end
      end
      S_FIRE: begin
        if (cnt_q != '0) begin
          pop      = 1'b1;
          fire_d   = 1'b1;
          skew_din = head;
          k_cnt_d  = k_cnt_q + KMAXW'(1);
          if (k_cnt_d == cfg_k_q) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // zeros drain the skew line; FIFO stays untouched
        fire_d   = 1'b1;
        fl_cnt_d = fl_cnt_q + FLW'(1);
        if (fl_cnt_q == FL_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        if (done_ack && tile_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d = S_IDLE;
      pop     = 1'b0;
      fire_d  = 1'b0;
      clr_d   = 1'b0;
      err_d   = 1'b0;
    end

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      k_cnt_q  <= '0;
      cfg_k_q  <= '0;
      fl_cnt_q <= '0;
      fire_q   <= 1'b0;
      clr_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      k_cnt_q  <= k_cnt_d;
      cfg_k_q  <= cfg_k_d;
      fl_cnt_q <= fl_cnt_d;
      fire_q   <= fire_d;
      clr_q    <= clr_d;
      err_q    <= err_d;
    end
  end

  // storage only; occupancy is tracked by the reset pointers/count
  always_ff @(posedge clk) begin
    if (push && rstn) mem_q[wr_ptr_q] <= {in_a, in_w};
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_a
    sa_skew_lane #(.W(INWIDTH), .STAGES(r + 1)) u_lane (
      .clk  (clk),
      .rstn (rstn),
      .en   (fire_d),
      .clr  (flush),
      .din  (skew_din[WW + r*INWIDTH +: INWIDTH]),
      .dout (arr_a[r*INWIDTH +: INWIDTH])
    );
  end

  for (genvar c = 0; c < COLS; c++) begin : g_w
    sa_skew_lane #(.W(INWIDTH), .STAGES(c + 1)) u_lane (
      .clk  (clk),
      .rstn (rstn),
      .en   (fire_d),
      .clr  (flush),
      .din  (skew_din[c*INWIDTH +: INWIDTH]),
      .dout (arr_w[c*INWIDTH +: INWIDTH])
    );
  end

  // the final flush fire overlaps the first DONE cycle; hold tile_done off until it retires
  assign tile_done = (state_q == S_DONE) && !fire_q;
  assign busy      = (state_q != S_IDLE);
  assign arr_fire  = fire_q;
  assign arr_clr   = clr_q;
  assign err       = err_q;
  assign fifo_cnt  = cnt_q;
endmodule
